fifo_wr_ctrl: RTL and testbench
===============================

# fifo_wr_ctrl

Write-domain controller for the asynchronous FIFO. It accepts write requests, owns the binary and Gray write pointers, and drives write port A of the dual-port RAM (`ena`, `wea`, `addra`, `dina`). It synchronises the read-domain Gray pointer into `wclk` to generate `wfull`, an optional almost-full flag, and a sticky overflow flag. Its output `wptr_gray` is exported to the read-domain controller.

## Interface
Parameters:
- `DATESIZE`, 8: data word width, equal to the RAM data width.
- `ADDRSIZE`, 4: RAM address width. Depth = 2^ADDRSIZE. Pointers are ADDRSIZE+1 bits.
- `SYNC_STAGES`, 2: flop stages on `rptr_gray` into `wclk`. Legal minimum is 2.
- `AF_LEVEL`, 12: fill level at or above which `walmost_full` asserts. Range 1..2^ADDRSIZE.

Ports:
- `wclk`  in  1  write clock; the only clock in this block.
- `wrst`  in  1  reset, synchronous, active-high.
- `winc`  in  1  write request for this cycle.
- `wdata`  in  DATESIZE  write data.
- `rptr_gray`  in  ADDRSIZE+1  read pointer in Gray code, from the read domain (asynchronous).
- `ena`  out  1  RAM port A enable.
- `wea`  out  1  RAM port A write enable.
- `addra`  out  ADDRSIZE  RAM port A address.
- `dina`  out  DATESIZE  RAM port A data.
- `wptr_gray`  out  ADDRSIZE+1  registered Gray write pointer, sent to the read domain.
- `wfull`  out  1  FIFO full, registered.
- `walmost_full`  out  1  level >= AF_LEVEL, registered. Present only when the macro is defined.
- `wovf`  out  1  sticky overflow flag.

## Operation
- Write accepted when `wen = winc & ~wfull`.
- `ena = wea = wen`, combinational. `addra = wbin[ADDRSIZE-1:0]`. `dina = wdata`, passed through.
- On an accepted write:
  - `wbin_next = wbin + 1`, modulo 2^(ADDRSIZE+1).
  - `wgray_next = wbin_next ^ (wbin_next >> 1)`.
- Synchroniser: a SYNC_STAGES-deep flop chain on `rptr_gray` produces `rq_gray`. No other logic uses the raw `rptr_gray`.
- Full: `wfull <= (wgray_next == {~rq_gray[A:A-1], rq_gray[A-2:0]})`, where A = ADDRSIZE.
- Overflow: if `winc & wfull`, the write is dropped. No RAM write occurs, pointers hold, and `wovf <= 1`. `wovf` clears only on `wrst`.
- Wrap-around: `addra` goes 2^ADDRSIZE-1 -> 0. The pointer MSB toggles every full lap.
- Reset (`wrst`=1 at a `wclk` edge), including mid-stream:
  - `wbin`, `wptr_gray`, synchroniser flops, `wfull`, `walmost_full` and `wovf` all go to 0.
  - `ena` and `wea` are 0 while `wrst` is high, regardless of `winc`.
  - The read side must be reset in the same window. This is a system requirement, not enforced here.

## Timing
- Write latency: data is written to the RAM at the same `wclk` edge that samples `wen`=1. `wptr_gray` updates at that same edge.
- `wfull` asserts at the edge of the write that makes level = 2^ADDRSIZE. A `winc` in the next cycle is dropped.
- Full deassertion is pessimistic. `wfull` falls at the (SYNC_STAGES+1)th `wclk` edge after a stable change of `rptr_gray`: 3 edges with the default.
- `walmost_full` follows the same latencies as `wfull`: same-edge on writes, SYNC_STAGES+1 edges on reads.
- Simultaneous write and read-pointer advance: the write takes effect immediately. The read is seen SYNC_STAGES+1 edges later. The FIFO never overflows.

## Configuration
- `FIFO_WR_ALMOST_FULL_EN` defined:
  - Adds a Gray-to-binary conversion of `rq_gray` into `rq_bin`.
  - Computes `level_next = wbin_next - rq_bin` (ADDRSIZE+1 bits, modulo).
  - `walmost_full <= (level_next >= AF_LEVEL)`.
- Not defined:
  - No converter or subtractor is instantiated.
  - The `walmost_full` port is absent. All other behaviour is identical.

## Test plan
- Reset: assert `wrst` for 2 cycles with `winc`=1 -> all outputs 0, no RAM write, `addra`=0.
- Fill: `rptr_gray`=0, 16 consecutive writes of 0x00..0x0F -> `addra` steps 0..15, `wfull`=1 after the 16th edge, `wptr_gray`=5'b11000. A 17th `winc` -> `ena`=0 and `wovf`=1, held until `wrst`.
- Almost-full (macro on): `rptr_gray`=0 -> `walmost_full` rises at the 12th write edge. Change `rptr_gray` to 5'b00110 (4) when level=16 -> `wfull` falls at the 3rd edge and `walmost_full` stays 1 (level 12).
- Wrap: 100 writes with `rptr_gray` trailing by 8 entries -> `wfull` never asserts, `addra` wraps 15->0, and every `wptr_gray` change flips exactly one bit.
- Reset mid-stream: after 7 writes, pulse `wrst` -> `wptr_gray`=0 and `wovf`=0 on that edge. The next write uses `addra`=0.
- Macro off: the Fill scenario passes unchanged, and the build elaborates with no `walmost_full` port.

Source files
------------

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-domain controller of the asynchronous FIFO.
// Owns the binary and Gray write pointers and drives RAM write port A.
// Synchronises the read Gray pointer into wclk to produce the full,
// almost-full and sticky overflow flags.
// Optional feature macro: FIFO_WR_ALMOST_FULL_EN adds the walmost_full port
// and the level computation that feeds it.
module fifo_wr_ctrl #(
  parameter int DATESIZE    = 8,
  parameter int ADDRSIZE    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AF_LEVEL    = 12
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [DATESIZE-1:0] wdata,
  input  logic [ADDRSIZE:0]   rptr_gray,
  output logic                ena,
  output logic                wea,
  output logic [ADDRSIZE-1:0] addra,
  output logic [DATESIZE-1:0] dina,
  output logic [ADDRSIZE:0]   wptr_gray,
  output logic                wfull,
`ifdef FIFO_WR_ALMOST_FULL_EN
  output logic                walmost_full,
`endif
  output logic                wovf
);

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbin_next;
  logic [ADDRSIZE:0] wgray_next;
  logic [ADDRSIZE:0] rq_gray;
  logic [ADDRSIZE:0] sync_q [SYNC_STAGES];
  logic [ADDRSIZE:0] full_gray;
  logic              wen;

  // A write is accepted only when not full and not held in reset.
  always_comb begin
    wen = winc & ~wfull & ~wrst;
  end

  // RAM port A is driven straight from the accept decision and the pointer.
  always_comb begin
    ena   = wen;
    wea   = wen;
    addra = wbin[ADDRSIZE-1:0];
    dina  = wdata;
  end

  // Next pointer values; they equal the current ones when no write happens.
  always_comb begin
    wbin_next  = wbin + {{ADDRSIZE{1'b0}}, wen};
    wgray_next = wbin_next ^ (wbin_next >> 1);
  end

  // Full when the write pointer is one lap ahead of the synchronised read
  // pointer: in Gray code that is the top two bits inverted.
  always_comb begin
    full_gray = {~rq_gray[ADDRSIZE:ADDRSIZE-1], rq_gray[ADDRSIZE-2:0]};
  end

  // Read-pointer synchroniser; the last stage is the only consumer-visible copy.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= rptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_comb begin
    rq_gray = sync_q[SYNC_STAGES-1];
  end

  // Pointer, full and overflow registers.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin      <= '0;
      wptr_gray <= '0;
      wfull     <= 1'b0;
      wovf      <= 1'b0;
    end else begin
      wbin      <= wbin_next;
      wptr_gray <= wgray_next;
      wfull     <= (wgray_next == full_gray);
      if (winc & wfull) wovf <= 1'b1;
    end
  end

`ifdef FIFO_WR_ALMOST_FULL_EN
  localparam logic [ADDRSIZE:0] AF_THRESH = ADDRSIZE'(0) + (ADDRSIZE+1)'(AF_LEVEL);

  logic [ADDRSIZE:0] rq_bin;
  logic [ADDRSIZE:0] level_next;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rq_bin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) rq_bin[i] = ^(rq_gray >> i);
    level_next = wbin_next - rq_bin;
  end

  // Almost-full uses the same next-pointer view as full, so it shares its timing.
  always_ff @(posedge wclk) begin
    if (wrst) walmost_full <= 1'b0;
    else      walmost_full <= (level_next >= AF_THRESH);
  end
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Testbench for fifo_wr_ctrl: vector table for reset and fill/overflow,
// hand-written sequences for full release, mid-stream reset and wrap-around.
module tb_fifo_wr_ctrl;

  logic       wclk = 1'b0;
  logic       wrst;
  logic       winc;
  logic [7:0] wdata;
  logic [4:0] rptr_gray;
  logic       ena, wea;
  logic [3:0] addra;
  logic [7:0] dina;
  logic [4:0] wptr_gray;
  logic       wfull;
  logic       wovf;
`ifdef FIFO_WR_ALMOST_FULL_EN
  logic       walmost_full;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 wclk = ~wclk;

  fifo_wr_ctrl #(.DATESIZE(8), .ADDRSIZE(4), .SYNC_STAGES(2), .AF_LEVEL(12)) dut (
    .wclk        (wclk),
    .wrst        (wrst),
    .winc        (winc),
    .wdata       (wdata),
    .rptr_gray   (rptr_gray),
    .ena         (ena),
    .wea         (wea),
    .addra       (addra),
    .dina        (dina),
    .wptr_gray   (wptr_gray),
    .wfull       (wfull),
`ifdef FIFO_WR_ALMOST_FULL_EN
    .walmost_full(walmost_full),
`endif
    .wovf        (wovf)
  );

  typedef struct {
    logic       wrst;
    logic       winc;
    logic [7:0] wdata;
    logic [4:0] rptr;
    logic       e_ena;
    logic [3:0] e_addra;
    logic [4:0] e_gray;
    logic       e_full;
    logic       e_af;
    logic       e_ovf;
  } vec_t;

  vec_t tv[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] gray5(input int b);
    logic [4:0] x;
    x = 5'(b);
    return x ^ (x >> 1);
  endfunction

  // Drive inputs on the falling edge, check port A just after, registers after the rising edge.
  task automatic apply(input logic r, input logic w, input logic [7:0] d, input logic [4:0] rp);
    @(negedge wclk);
    wrst = r; winc = w; wdata = d; rptr_gray = rp;
    #1;
  endtask

  logic [4:0] prev_gray;
  logic       seen_wrap;

  initial begin
    wrst = 1'b1; winc = 1'b1; wdata = 8'hAA; rptr_gray = '0;

    // Two reset cycles with winc high, then 16 writes, then an overflow attempt and an idle.
    for (int i = 0; i < 2; i++)
      tv[i] = '{1'b1, 1'b1, 8'hAA, 5'd0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 16; i++)
      tv[2+i] = '{1'b0, 1'b1, 8'(i), 5'd0, 1'b1, 4'(i), gray5(i+1),
                  (i == 15), (i >= 11), 1'b0};
    tv[18] = '{1'b0, 1'b1, 8'h55, 5'd0, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 1'b1};
    tv[19] = '{1'b0, 1'b0, 8'h66, 5'd0, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 1'b1};

    @(posedge wclk);

    for (int i = 0; i < 20; i++) begin
      apply(tv[i].wrst, tv[i].winc, tv[i].wdata, tv[i].rptr);
      chk($sformatf("v%0d_ena", i),   32'(ena),   32'(tv[i].e_ena));
      chk($sformatf("v%0d_wea", i),   32'(wea),   32'(tv[i].e_ena));
      chk($sformatf("v%0d_addra", i), 32'(addra), 32'(tv[i].e_addra));
      chk($sformatf("v%0d_dina", i),  32'(dina),  32'(tv[i].wdata));
      @(posedge wclk); #1;
      chk($sformatf("v%0d_gray", i),  32'(wptr_gray), 32'(tv[i].e_gray));
      chk($sformatf("v%0d_full", i),  32'(wfull),     32'(tv[i].e_full));
      chk($sformatf("v%0d_ovf", i),   32'(wovf),      32'(tv[i].e_ovf));
`ifdef FIFO_WR_ALMOST_FULL_EN
      chk($sformatf("v%0d_af", i),    32'(walmost_full), 32'(tv[i].e_af));
`endif
    end

    // Read pointer moves to 4: full drops only at the third edge, almost-full holds (level 12).
    for (int e = 1; e <= 3; e++) begin
      apply(1'b0, 1'b0, 8'h00, 5'b00110);
      @(posedge wclk); #1;
      chk($sformatf("release_full_e%0d", e), 32'(wfull), (e < 3) ? 32'd1 : 32'd0);
`ifdef FIFO_WR_ALMOST_FULL_EN
      chk($sformatf("release_af_e%0d", e), 32'(walmost_full), 32'd1);
`endif
    end
    chk("ovf_sticky", 32'(wovf), 32'd1);

    apply(1'b0, 1'b1, 8'h77, 5'b00110);
    chk("post_release_ena", 32'(ena), 32'd1);
    chk("post_release_addra", 32'(addra), 32'd0);
    @(posedge wclk); #1;
    chk("post_release_gray", 32'(wptr_gray), 32'b11001);
    chk("post_release_full", 32'(wfull), 32'd0);

    // Drain: read pointer catches up to 17, then 7 writes and a reset mid-stream.
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b0, 8'h00, gray5(17));
      @(posedge wclk); #1;
    end
    for (int k = 0; k < 7; k++) begin
      apply(1'b0, 1'b1, 8'(8'h80 + k), gray5(17));
      chk($sformatf("mid_w%0d_addra", k), 32'(addra), 32'(k + 1));
      @(posedge wclk); #1;
    end
    chk("mid_pre_ovf", 32'(wovf), 32'd1);
    apply(1'b1, 1'b1, 8'h99, 5'd0);
    chk("mid_rst_ena", 32'(ena), 32'd0);
    chk("mid_rst_wea", 32'(wea), 32'd0);
    @(posedge wclk); #1;
    chk("mid_rst_gray", 32'(wptr_gray), 32'd0);
    chk("mid_rst_ovf", 32'(wovf), 32'd0);
    chk("mid_rst_full", 32'(wfull), 32'd0);
    apply(1'b0, 1'b1, 8'h11, 5'd0);
    chk("mid_next_ena", 32'(ena), 32'd1);
    chk("mid_next_addra", 32'(addra), 32'd0);
    @(posedge wclk); #1;
    chk("mid_next_gray", 32'(wptr_gray), 32'd1);

    // Wrap-around: fresh reset, then 100 writes with the reader trailing by 8.
    apply(1'b1, 1'b0, 8'h00, 5'd0);
    @(posedge wclk); #1;
    prev_gray = wptr_gray;
    seen_wrap = 1'b0;
    for (int i = 0; i < 100; i++) begin
      apply(1'b0, 1'b1, 8'(i), gray5((i >= 8) ? i - 8 : 0));
      chk($sformatf("wrap%0d_ena", i), 32'(ena), 32'd1);
      chk($sformatf("wrap%0d_addra", i), 32'(addra), 32'(i % 16));
      if (i > 0 && addra == 4'd0) seen_wrap = 1'b1;
      @(posedge wclk); #1;
      chk($sformatf("wrap%0d_onebit", i), 32'($countones(wptr_gray ^ prev_gray)), 32'd1);
      chk($sformatf("wrap%0d_gray", i), 32'(wptr_gray), 32'(gray5(i + 1)));
      chk($sformatf("wrap%0d_full", i), 32'(wfull), 32'd0);
      prev_gray = wptr_gray;
    end
    chk("wrap_seen", 32'(seen_wrap), 32'd1);
    chk("wrap_ovf", 32'(wovf), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
